car: RTL and testbench
======================

CAR -- requirements
Module: car

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named as follows.
- clk_M  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous active-high reset.
REQ-002 SHALL have the remaining ports:
- start  in  1  1 = trip active; 0 = idle/price-edit mode.
- pause  in  1  1 = freeze all trip counting.
- waitL  in  1  1 = waiting (motor stopped, wait time accrues).
- speedup  in  2  motor speed select.
- p_m  in  1  price selector for keypad edit: 0 = per-km price, 1 = wait price.
- Dir  in  1  motor direction.
- row  in  4  keypad rows, active-low.
- StepDrive  out  4  one-hot stepper phase drive.
- col  out  4  keypad column scan, active-low.
- distance_b  out  16  4-digit BCD distance, XXX.X km.
- fee_b  out  16  4-digit BCD total fare, XXX.X yuan.
- s_fee_b  out  16  BCD mileage fee.
- g_fee_b  out  16  BCD waiting fee.
- flag  out  1  1 while the motor is moving.

Function
REQ-003 SHALL be "moving" when start=1, pause=0 and waitL=0; pause has priority over waitL, and waitL has priority over moving.
REQ-004 SHALL generate a step tick every P cycles while moving: speedup 00 → 20,000; 01 → 5,000; 10 → 2,500; 11 → 1,250.
REQ-005 SHALL advance StepDrive on each step tick. Dir=0 sequence: 0001→0010→0100→1000→0001. Dir=1 uses the reverse order. Output SHALL be 0000 when not moving.
REQ-006 SHALL increment distance_b by 0.1 km every 10 step ticks, in BCD, saturating at 999.9.
REQ-007 SHALL accrue one wait unit every 1,000,000 cycles while start=1, waitL=1 and pause=0, and add the wait price to g_fee_b at each unit.
REQ-008 SHALL handle mileage fee as follows:
- Start fare is 8.0 yuan and covers the first 3.0 km.
- For each 0.1 km beyond 3.0 km, add (per-km price in yuan) × 0.1 to s_fee_b.
REQ-009 SHALL set fee_b = 8.0 + s_fee_b + g_fee_b in BCD while start=1, saturating at 999.9; fee_b SHALL be 0000 when start=0.
REQ-010 SHALL clear distance, fee and timer counters on the falling edge of start; prices are retained.
REQ-011 SHALL freeze all counters and timers, holding their values, while pause=1.
REQ-012 SHALL drive flag = moving.
REQ-013 SHALL handle keypad scanning and decoding as follows:
- col drives one column low at a time, rotating col[0]..col[3] every 1,250 cycles.
- Key code = 4×(index of low row) + (index of low column).
REQ-014 SHALL accept a key only after the same code is detected in 3 consecutive full scans; one accept per press, with re-arm after release.
REQ-015 SHALL handle an accepted key as follows:
- Code 0–9 while start=0 sets the price selected by p_m to that value in whole yuan.
- Codes A–F, and any key while start=1, SHALL be ignored.
REQ-016 SHALL use default prices of 2 yuan/km and 1.0 yuan/wait unit.

Reset
REQ-017 SHALL, on reset, asynchronously set: StepDrive=0000, col=1110, all BCD outputs 0000, flag=0, all timers and debounce state 0, prices to their defaults.
REQ-018 SHALL, on reset asserted mid-trip, abort the trip immediately; counting restarts from zero after reset release with start=1.

Configuration
REQ-019 SHALL compile in keypad price editing (REQ-013..015) when macro CAR_KEYPAD_EN is defined. Without it: col is constant 1111, row is ignored, and prices are fixed at their defaults.

Verification
REQ-020 SHALL cover: reset, then start=1, speedup=00, Dir=0, run 240 ms → distance_b=0030, s_fee_b=0000, fee_b=0080, StepDrive rotating 0001→0010→…, flag=1.
REQ-021 SHALL cover: pause=1 for 200 ms → all outputs unchanged, StepDrive=0000, flag=0.
REQ-022 SHALL cover: waitL=1 for 400 ms with default price → g_fee_b=0100, distance_b unchanged.
REQ-023 SHALL cover: reset, then start=1, speedup=01 for 40 ms → distance_b=0020, fee_b=0080.
REQ-024 SHALL cover: reset, start=0, p_m=0, key 3 held 1 ms then released, start=1, speedup=00 for 400 ms → per-km price 3; distance_b=0050; s_fee_b=0060; fee_b=0140.
REQ-025 SHALL cover: Dir=1 while moving → StepDrive sequence 1000→0100→0010→0001.

Source files
------------

// File: rtl/car.sv
// Taximeter: stepper-motor drive, BCD distance/fare accounting and optional keypad price entry.
// Define CAR_KEYPAD_EN to build in keypad scanning and price editing; otherwise prices are fixed.
module car #(
    parameter int unsigned P_SPD0   = 20000,
    parameter int unsigned P_SPD1   = 5000,
    parameter int unsigned P_SPD2   = 2500,
    parameter int unsigned P_SPD3   = 1250,
    parameter int unsigned WAIT_DIV = 1000000,
    parameter int unsigned SCAN_DIV = 1250
) (
    input  logic        clk_M,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        waitL,
    input  logic [1:0]  speedup,
    input  logic        p_m,
    input  logic        Dir,
    input  logic [3:0]  row,
    output logic [3:0]  StepDrive,
    output logic [3:0]  col,
    output logic [15:0] distance_b,
    output logic [15:0] fee_b,
    output logic [15:0] s_fee_b,
    output logic [15:0] g_fee_b,
    output logic        flag
);
    localparam int unsigned SW = $clog2(P_SPD0 + 1);
    localparam int unsigned WW = $clog2(WAIT_DIV + 1);
    localparam logic [3:0] KM_PRICE_DEF   = 4'd2;
    localparam logic [3:0] WAIT_PRICE_DEF = 4'd1;

    // 4-digit BCD add; a carry out of the top digit saturates to 999.9.
    function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  s;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        if (c) r = 16'h9999;
        return r;
    endfunction

    logic          moving, waiting, clear, step_tick, dist_inc, wait_unit;
    logic          start_q;
    logic [SW-1:0] step_cnt_q, step_cnt_d, period_m1;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [3:0]    tick10_q, tick10_d;
    logic [15:0]   dist_q, dist_d, s_fee_q, s_fee_d, g_fee_q, g_fee_d, fee_q, fee_d;
    logic [3:0]    drive_q, drive_d;
    logic          flag_q;
    logic [3:0]    km_price, wait_price;

    always_comb begin
        case (speedup)
            2'b00:   period_m1 = SW'(P_SPD0 - 1);
            2'b01:   period_m1 = SW'(P_SPD1 - 1);
            2'b10:   period_m1 = SW'(P_SPD2 - 1);
            default: period_m1 = SW'(P_SPD3 - 1);
        endcase
    end

    always_comb begin
        moving    = start & ~pause & ~waitL;
        waiting   = start & ~pause & waitL;
        clear     = start_q & ~start;
        step_tick = moving && (step_cnt_q >= period_m1);
        dist_inc  = step_tick && (tick10_q == 4'd9);
        wait_unit = waiting && (wait_cnt_q >= WW'(WAIT_DIV - 1));

        step_cnt_d = step_cnt_q;
        wait_cnt_d = wait_cnt_q;
        phase_d    = phase_q;
        tick10_d   = tick10_q;
        dist_d     = dist_q;
        s_fee_d    = s_fee_q;
        g_fee_d    = g_fee_q;

        if (clear) begin
            step_cnt_d = '0;
            wait_cnt_d = '0;
            phase_d    = '0;
            tick10_d   = '0;
            dist_d     = '0;
            s_fee_d    = '0;
            g_fee_d    = '0;
        end else begin
            if (moving) step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
            if (step_tick) begin
                phase_d  = Dir ? phase_q - 2'd1 : phase_q + 2'd1;
                tick10_d = dist_inc ? '0 : tick10_q + 4'd1;
            end
            // Mileage fee accrues only for 0.1 km units that end beyond 3.0 km.
            if (dist_inc && (dist_q != 16'h9999)) begin
                dist_d = bcd_add(dist_q, 16'h0001);
                if (dist_q >= 16'h0030) s_fee_d = bcd_add(s_fee_q, {12'h000, km_price});
            end
            if (waiting) wait_cnt_d = wait_unit ? '0 : wait_cnt_q + 1'b1;
            if (wait_unit) g_fee_d = bcd_add(g_fee_q, {8'h00, wait_price, 4'h0});
        end

        fee_d   = start ? bcd_add(bcd_add(16'h0080, s_fee_d), g_fee_d) : '0;
        drive_d = moving ? (4'b0001 << phase_d) : '0;
    end

    always_ff @(posedge clk_M or posedge reset) begin
        if (reset) begin
            start_q    <= 1'b0;
            step_cnt_q <= '0;
            wait_cnt_q <= '0;
            phase_q    <= '0;
            tick10_q   <= '0;
            dist_q     <= '0;
            s_fee_q    <= '0;
            g_fee_q    <= '0;
            fee_q      <= '0;
            drive_q    <= '0;
            flag_q     <= 1'b0;
        end else begin
            start_q    <= start;
            step_cnt_q <= step_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            phase_q    <= phase_d;
            tick10_q   <= tick10_d;
            dist_q     <= dist_d;
            s_fee_q    <= s_fee_d;
            g_fee_q    <= g_fee_d;
            fee_q      <= fee_d;
            drive_q    <= drive_d;
            flag_q     <= moving;
        end
    end

    assign StepDrive  = drive_q;
    assign flag       = flag_q;
    assign distance_b = dist_q;
    assign s_fee_b    = s_fee_q;
    assign g_fee_b    = g_fee_q;
    assign fee_b      = fee_q;

`ifdef CAR_KEYPAD_EN
    localparam int unsigned KW = $clog2(SCAN_DIV + 1);

    logic [KW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    col_idx_q, col_idx_d, match_cnt_q, match_cnt_d, row_idx;
    logic          cur_hit_q, cur_hit_d, locked_q, locked_d;
    logic [3:0]    cur_code_q, cur_code_d, last_code_q, last_code_d, code_now;
    logic [3:0]    km_price_q, km_price_d, wait_price_q, wait_price_d;
    logic          scan_tick, row_hit, hit_now, accept;

    always_comb begin
        row_hit = 1'b1;
        row_idx = 2'd0;
        if (!row[0])      row_idx = 2'd0;
        else if (!row[1]) row_idx = 2'd1;
        else if (!row[2]) row_idx = 2'd2;
        else if (!row[3]) row_idx = 2'd3;
        else              row_hit = 1'b0;
    end

    // A scan's key code is latched from the first column that saw a low row.
    always_comb begin
        scan_tick    = (scan_cnt_q >= KW'(SCAN_DIV - 1));
        scan_cnt_d   = scan_tick ? '0 : scan_cnt_q + 1'b1;
        col_idx_d    = col_idx_q;
        cur_hit_d    = cur_hit_q;
        cur_code_d   = cur_code_q;
        last_code_d  = last_code_q;
        match_cnt_d  = match_cnt_q;
        locked_d     = locked_q;
        km_price_d   = km_price_q;
        wait_price_d = wait_price_q;
        hit_now      = cur_hit_q | row_hit;
        code_now     = cur_hit_q ? cur_code_q : {row_idx, col_idx_q};
        accept       = 1'b0;

        if (scan_tick) begin
            col_idx_d = col_idx_q + 2'd1;
            if (col_idx_q == 2'd3) begin
                cur_hit_d   = 1'b0;
                cur_code_d  = '0;
                last_code_d = code_now;
                if (!hit_now) begin
                    match_cnt_d = '0;
                    locked_d    = 1'b0;
                end else begin
                    if ((match_cnt_q != 2'd0) && (code_now == last_code_q))
                        match_cnt_d = (match_cnt_q == 2'd3) ? 2'd3 : match_cnt_q + 2'd1;
                    else
                        match_cnt_d = 2'd1;
                    if ((match_cnt_d == 2'd3) && !locked_q) begin
                        accept   = 1'b1;
                        locked_d = 1'b1;
                    end
                end
            end else begin
                cur_hit_d  = hit_now;
                cur_code_d = code_now;
            end
        end

        if (accept && !start && (code_now <= 4'd9)) begin
            if (p_m) wait_price_d = code_now;
            else     km_price_d   = code_now;
        end
    end

    always_ff @(posedge clk_M or posedge reset) begin
        if (reset) begin
            scan_cnt_q   <= '0;
            col_idx_q    <= '0;
            cur_hit_q    <= 1'b0;
            cur_code_q   <= '0;
            last_code_q  <= '0;
            match_cnt_q  <= '0;
            locked_q     <= 1'b0;
            km_price_q   <= KM_PRICE_DEF;
            wait_price_q <= WAIT_PRICE_DEF;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            col_idx_q    <= col_idx_d;
            cur_hit_q    <= cur_hit_d;
            cur_code_q   <= cur_code_d;
            last_code_q  <= last_code_d;
            match_cnt_q  <= match_cnt_d;
            locked_q     <= locked_d;
            km_price_q   <= km_price_d;
            wait_price_q <= wait_price_d;
        end
    end

    assign col        = ~(4'b0001 << col_idx_q);
    assign km_price   = km_price_q;
    assign wait_price = wait_price_q;
`else
    logic unused_keypad;

    assign unused_keypad = (^{row, p_m}) ^ (SCAN_DIV == 0);
    assign col           = 4'b1111;
    assign km_price      = KM_PRICE_DEF;
    assign wait_price    = WAIT_PRICE_DEF;
`endif

endmodule

// File: tb/tb_car.sv
// Directed bench for car; dividers scaled down by 1250 so 1 ms of trip time is 20 clock cycles.
module tb_car;
    localparam int unsigned MS = 20;

`ifdef CAR_KEYPAD_EN
    localparam logic [3:0]  COL_RST   = 4'b1110;
    localparam logic [15:0] S_FEE_31  = 16'h0003;
    localparam logic [15:0] S_FEE_50  = 16'h0060;
    localparam logic [15:0] FEE_50    = 16'h0140;
`else
    localparam logic [3:0]  COL_RST   = 4'b1111;
    localparam logic [15:0] S_FEE_31  = 16'h0002;
    localparam logic [15:0] S_FEE_50  = 16'h0040;
    localparam logic [15:0] FEE_50    = 16'h0120;
`endif

    logic        clk_M = 1'b0;
    logic        reset, start, pause, waitL, p_m, Dir;
    logic [1:0]  speedup;
    logic [3:0]  row, StepDrive, col;
    logic [15:0] distance_b, fee_b, s_fee_b, g_fee_b;
    logic        flag;
    logic        key_on;
    logic [1:0]  key_r, key_c;
    logic [3:0]  exp_sd;
    int          n_cmp = 0;
    int          n_bad = 0;

    car #(
        .P_SPD0(16), .P_SPD1(4), .P_SPD2(2), .P_SPD3(1), .WAIT_DIV(800), .SCAN_DIV(1)
    ) dut (
        .clk_M(clk_M), .reset(reset), .start(start), .pause(pause), .waitL(waitL),
        .speedup(speedup), .p_m(p_m), .Dir(Dir), .row(row), .StepDrive(StepDrive),
        .col(col), .distance_b(distance_b), .fee_b(fee_b), .s_fee_b(s_fee_b),
        .g_fee_b(g_fee_b), .flag(flag)
    );

    always #20 clk_M = ~clk_M;

    // Keypad model: the pressed key pulls its row low while its column is driven low.
    assign row = (key_on && (col[key_c] == 1'b0)) ? ~(4'b0001 << key_r) : 4'hF;

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk_M);
        #1;
    endtask

    task automatic press_key(input logic [1:0] r, input logic [1:0] c);
        key_r = r; key_c = c; key_on = 1'b1;
        cycles(1 * MS);
        key_on = 1'b0;
        cycles(10);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 0; pause = 0; waitL = 0; p_m = 0; Dir = 0; speedup = 2'b00;
        key_on = 0; key_r = 0; key_c = 0;
        cycles(3);
        n_cmp++; if (StepDrive !== 4'b0000) begin n_bad++; $display("FAIL rst_step: got %b want 0000", StepDrive); end
        n_cmp++; if (col !== COL_RST) begin n_bad++; $display("FAIL rst_col: got %b want %b", col, COL_RST); end
        n_cmp++; if ({distance_b, fee_b, s_fee_b, g_fee_b} !== 64'h0) begin n_bad++; $display("FAIL rst_bcd: got %h want 0", {distance_b, fee_b, s_fee_b, g_fee_b}); end
        n_cmp++; if (flag !== 1'b0) begin n_bad++; $display("FAIL rst_flag: got %b want 0", flag); end
        reset = 1'b0;
    endtask

    task automatic test_run;
        start = 1'b1;
        cycles(240 * MS);
        n_cmp++; if (distance_b !== 16'h0030) begin n_bad++; $display("FAIL run_dist: got %h want 0030", distance_b); end
        n_cmp++; if (s_fee_b !== 16'h0000) begin n_bad++; $display("FAIL run_sfee: got %h want 0000", s_fee_b); end
        n_cmp++; if (fee_b !== 16'h0080) begin n_bad++; $display("FAIL run_fee: got %h want 0080", fee_b); end
        n_cmp++; if (flag !== 1'b1) begin n_bad++; $display("FAIL run_flag: got %b want 1", flag); end
        n_cmp++; if (StepDrive !== 4'b0001) begin n_bad++; $display("FAIL run_step0: got %b want 0001", StepDrive); end
        for (int i = 1; i <= 4; i++) begin
            cycles(16);
            exp_sd = 4'b0001 << (i % 4);
            n_cmp++; if (StepDrive !== exp_sd) begin n_bad++; $display("FAIL run_step%0d: got %b want %b", i, StepDrive, exp_sd); end
        end
    endtask

    task automatic test_pause;
        pause = 1'b1;
        cycles(200 * MS);
        n_cmp++; if (distance_b !== 16'h0030) begin n_bad++; $display("FAIL pause_dist: got %h want 0030", distance_b); end
        n_cmp++; if (fee_b !== 16'h0080) begin n_bad++; $display("FAIL pause_fee: got %h want 0080", fee_b); end
        n_cmp++; if (g_fee_b !== 16'h0000) begin n_bad++; $display("FAIL pause_gfee: got %h want 0000", g_fee_b); end
        n_cmp++; if (StepDrive !== 4'b0000) begin n_bad++; $display("FAIL pause_step: got %b want 0000", StepDrive); end
        n_cmp++; if (flag !== 1'b0) begin n_bad++; $display("FAIL pause_flag: got %b want 0", flag); end
    endtask

    task automatic test_wait;
        pause = 1'b0; waitL = 1'b1;
        cycles(400 * MS);
        n_cmp++; if (g_fee_b !== 16'h0100) begin n_bad++; $display("FAIL wait_gfee: got %h want 0100", g_fee_b); end
        n_cmp++; if (distance_b !== 16'h0030) begin n_bad++; $display("FAIL wait_dist: got %h want 0030", distance_b); end
        n_cmp++; if (fee_b !== 16'h0180) begin n_bad++; $display("FAIL wait_fee: got %h want 0180", fee_b); end
        n_cmp++; if (flag !== 1'b0) begin n_bad++; $display("FAIL wait_flag: got %b want 0", flag); end
    endtask

    task automatic test_reset_mid_trip;
        #5 reset = 1'b1;
        #1;
        n_cmp++; if ({distance_b, fee_b, g_fee_b} !== 48'h0) begin n_bad++; $display("FAIL midrst_bcd: got %h want 0", {distance_b, fee_b, g_fee_b}); end
        waitL = 1'b0; speedup = 2'b01;
        @(posedge clk_M); #1;
        reset = 1'b0;
        cycles(40 * MS);
        n_cmp++; if (distance_b !== 16'h0020) begin n_bad++; $display("FAIL spd1_dist: got %h want 0020", distance_b); end
        n_cmp++; if (fee_b !== 16'h0080) begin n_bad++; $display("FAIL spd1_fee: got %h want 0080", fee_b); end
        n_cmp++; if (g_fee_b !== 16'h0000) begin n_bad++; $display("FAIL spd1_gfee: got %h want 0000", g_fee_b); end
    endtask

    task automatic test_dir_reverse;
        Dir = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycles(4);
            exp_sd = 4'b1000 >> ((i - 1) % 4);
            n_cmp++; if (StepDrive !== exp_sd) begin n_bad++; $display("FAIL rev_step%0d: got %b want %b", i, StepDrive, exp_sd); end
        end
    endtask

    task automatic test_keypad;
        reset = 1'b1; start = 0; Dir = 0; speedup = 2'b00; p_m = 0;
        cycles(2);
        reset = 1'b0;
        press_key(2'd2, 2'd2);
        press_key(2'd0, 2'd3);
        n_cmp++; if (fee_b !== 16'h0000) begin n_bad++; $display("FAIL idle_fee: got %h want 0000", fee_b); end
        start = 1'b1;
        cycles(240 * MS);
        n_cmp++; if (s_fee_b !== 16'h0000) begin n_bad++; $display("FAIL key_sfee30: got %h want 0000", s_fee_b); end
        cycles(8 * MS);
        n_cmp++; if (distance_b !== 16'h0031) begin n_bad++; $display("FAIL key_dist31: got %h want 0031", distance_b); end
        n_cmp++; if (s_fee_b !== S_FEE_31) begin n_bad++; $display("FAIL key_sfee31: got %h want %h", s_fee_b, S_FEE_31); end
        cycles(152 * MS);
        n_cmp++; if (distance_b !== 16'h0050) begin n_bad++; $display("FAIL key_dist50: got %h want 0050", distance_b); end
        n_cmp++; if (s_fee_b !== S_FEE_50) begin n_bad++; $display("FAIL key_sfee50: got %h want %h", s_fee_b, S_FEE_50); end
        n_cmp++; if (fee_b !== FEE_50) begin n_bad++; $display("FAIL key_fee50: got %h want %h", fee_b, FEE_50); end
    endtask

    task automatic test_stop_restart;
        start = 1'b0;
        cycles(2);
        n_cmp++; if ({distance_b, s_fee_b, fee_b} !== 48'h0) begin n_bad++; $display("FAIL stop_clear: got %h want 0", {distance_b, s_fee_b, fee_b}); end
        start = 1'b1;
        cycles(248 * MS);
        n_cmp++; if (distance_b !== 16'h0031) begin n_bad++; $display("FAIL restart_dist: got %h want 0031", distance_b); end
        n_cmp++; if (s_fee_b !== S_FEE_31) begin n_bad++; $display("FAIL restart_sfee: got %h want %h", s_fee_b, S_FEE_31); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause();
        test_wait();
        test_reset_mid_trip();
        test_dir_reverse();
        test_keypad();
        test_stop_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
